bwt_stream_ctrl: RTL and testbench

Parametrised control and buffering front-end for the BWT suffix-sort engine. It accepts a string as a stream of fixed-width beats on a valid/ready interface and assembles the full string. It launches the sort engine, supervises it with a timeout, and captures the result. It streams the result back out in beats with backpressure, together with the index of the sentinel symbol in the result.

---
 rtl/bwt_pkg.sv | 9 +
 rtl/bwt_sentinel_find.sv | 23 ++
 rtl/bwt_stream_ctrl.sv | 115 +++++++++++
 tb/tb_bwt_stream_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bwt_pkg.sv
// bwt_pkg: shared controller state type, default element constants and beat-count helper
package bwt_pkg;
    typedef enum logic [2:0] {LOAD, DISCARD, LAUNCH, WAIT, SEND} state_t;
    localparam int ELEM_W_DEF = 8;
    localparam logic [7:0] SENTINEL_DEF = 8'h24;
    function automatic int beats(input int string_len, input int beat_elems);
        return string_len / beat_elems;
    endfunction
endpackage

// File: rtl/bwt_sentinel_find.sv
// bwt_sentinel_find: combinational priority scan for the lowest element equal to the sentinel
module bwt_sentinel_find import bwt_pkg::*; #(
    parameter int N = 32,
    parameter int W = ELEM_W_DEF,
    parameter logic [W-1:0] SENT = W'(SENTINEL_DEF)
) (
    input  logic [N*W-1:0]       data,
    output logic [$clog2(N)-1:0] idx,
    output logic                 found
);
    localparam int IW = $clog2(N);
    // scan from the top down so the lowest matching index is the one left standing
    always_comb begin
        idx = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (data[i*W +: W] == SENT) begin
                idx = IW'(i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/bwt_stream_ctrl.sv
// bwt_stream_ctrl: assembles a beat-streamed string, runs the sort engine under a timeout, streams the result back
module bwt_stream_ctrl import bwt_pkg::*; #(
    parameter int STRING_LEN = 32,
    parameter int ELEM_W = ELEM_W_DEF,
    parameter int BEAT_ELEMS = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter logic [ELEM_W-1:0] SENTINEL = ELEM_W'(SENTINEL_DEF)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [BEAT_ELEMS*ELEM_W-1:0]   in_data,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [BEAT_ELEMS*ELEM_W-1:0]   out_data,
    output logic                           out_last,
    output logic                           eng_start,
    output logic [STRING_LEN*ELEM_W-1:0]   eng_string,
    input  logic                           eng_done,
    input  logic [STRING_LEN*ELEM_W-1:0]   eng_result,
    output logic                           busy,
    output logic [$clog2(STRING_LEN)-1:0]  sentinel_idx,
    output logic                           err_len,
    output logic                           err_timeout,
    output logic                           err_nosentinel
);
    localparam int BEATS = beats(STRING_LEN, BEAT_ELEMS);
    localparam int BEAT_W = BEAT_ELEMS * ELEM_W;
    localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int IW = $clog2(STRING_LEN);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT_CYCLES - 1);

    state_t state, state_nx;
    logic [BW-1:0] beat_cnt, out_beat;
    logic [TW-1:0] tcnt;
    logic [STRING_LEN*ELEM_W-1:0] res_buf;
    logic [IW-1:0] find_idx;
    logic find_ok, in_acc, out_acc, in_final, timed_out;

    assign in_acc = in_valid && in_ready;
    assign out_acc = out_valid && out_ready;
    assign in_final = beat_cnt == LAST_BEAT;
    assign timed_out = tcnt == LAST_TICK;

    bwt_sentinel_find #(.N(STRING_LEN), .W(ELEM_W), .SENT(SENTINEL)) u_find (
        .data(eng_result),
        .idx(find_idx),
        .found(find_ok)
    );

    // state register
    always_ff @(posedge clk) state <= rst ? LOAD : state_nx;

    // next state: frame length checks, engine supervision (done beats timeout), output drain
    always_comb begin
        state_nx = state;
        case (state)
            LOAD:    if (in_acc && in_final) state_nx = in_last ? LAUNCH : DISCARD;
            DISCARD: if (in_acc && in_last) state_nx = LOAD;
            LAUNCH:  state_nx = WAIT;
            WAIT:    if (eng_done) state_nx = SEND; else if (timed_out) state_nx = LOAD;
            SEND:    if (out_acc && out_last) state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    // handshake and status outputs decoded from the current state
    always_comb begin
        in_ready = state == LOAD || state == DISCARD;
        out_valid = state == SEND;
        out_last = out_valid && out_beat == LAST_BEAT;
        out_data = out_valid ? res_buf[out_beat*BEAT_W +: BEAT_W] : '0;
        eng_start = state == LAUNCH;
        busy = state != LOAD;
    end

    // string assembly, timeout counting, result capture and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            out_beat <= '0;
            tcnt <= '0;
            eng_string <= '0;
            res_buf <= '0;
            sentinel_idx <= '0;
            err_len <= 1'b0;
            err_timeout <= 1'b0;
            err_nosentinel <= 1'b0;
        end else begin
            if (state == LOAD && in_acc) begin
                eng_string[beat_cnt*BEAT_W +: BEAT_W] <= in_data;
                beat_cnt <= (in_last || in_final) ? '0 : beat_cnt + 1'b1;
                if (beat_cnt == '0) {err_len, err_timeout, err_nosentinel} <= '0;
                if (in_last != in_final) err_len <= 1'b1;
            end
            if (state == LAUNCH) tcnt <= '0;
            if (state == WAIT) begin
                tcnt <= tcnt + 1'b1;
                if (eng_done) begin
                    res_buf <= eng_result;
                    sentinel_idx <= find_idx;
                    err_nosentinel <= !find_ok;
                    out_beat <= '0;
                end else if (timed_out) begin
                    err_timeout <= 1'b1;
                end
            end
            if (state == SEND && out_acc) out_beat <= out_last ? '0 : out_beat + 1'b1;
        end
    end
endmodule

// File: tb/tb_bwt_stream_ctrl.sv
// tb_bwt_stream_ctrl: randomized scenario bench with a behavioural engine and frame-level reference model
`timescale 1ns/1ps
module tb_bwt_stream_ctrl;
    localparam int SL = 8, BE = 4, EW = 8, TO = 16, NB = SL / BE, BW = BE * EW, SW = SL * EW;
    localparam logic [7:0] SENT = 8'h24;

    logic clk = 1'b0, rst = 1'b1;
    logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0, eng_done = 1'b0;
    logic in_ready, out_valid, out_last, eng_start, busy, err_len, err_timeout, err_nosentinel;
    logic [BW-1:0] in_data = '0, out_data;
    logic [SW-1:0] eng_string, eng_result = '0, eng_res = '0;
    logic [2:0] sentinel_idx;
    int tests = 0, fails = 0;
    int eng_lat = 10, eng_starts = 0, eng_cnt = -1;

    bwt_stream_ctrl #(.STRING_LEN(SL), .ELEM_W(EW), .BEAT_ELEMS(BE), .TIMEOUT_CYCLES(TO), .SENTINEL(SENT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .eng_start(eng_start), .eng_string(eng_string), .eng_done(eng_done), .eng_result(eng_result),
        .busy(busy), .sentinel_idx(sentinel_idx),
        .err_len(err_len), .err_timeout(err_timeout), .err_nosentinel(err_nosentinel)
    );

    always #5 clk = ~clk;

    // engine model: strobes done with the chosen result eng_lat cycles after each start, garbage otherwise
    always @(negedge clk) begin
        eng_done = 1'b0;
        eng_result = {$urandom, $urandom};
        if (eng_start === 1'b1) begin
            eng_starts++;
            eng_cnt = eng_lat;
        end else if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                eng_done = 1'b1;
                eng_result = eng_res;
                eng_cnt = -1;
            end
        end
    end

    function automatic logic [SW-1:0] pack(input string s);
        logic [SW-1:0] v = '0;
        for (int i = 0; i < SL; i++) v[i*EW +: EW] = s[i];
        return v;
    endfunction

    function automatic int ref_idx(input logic [SW-1:0] r);
        logic [7:0] e [SL];
        for (int i = 0; i < SL; i++) e[i] = r[i*EW +: EW];
        for (int i = 0; i < SL; i++) if (e[i] == SENT) return i;
        return -1;
    endfunction

    function automatic logic [SW-1:0] rand_str(input bit allow_sent);
        string alpha = "ACGT$";
        logic [SW-1:0] v = '0;
        for (int i = 0; i < SL; i++) v[i*EW +: EW] = alpha[$urandom_range(0, allow_sent ? 4 : 3)];
        return v;
    endfunction

    task automatic send(input logic [SW-1:0] s, input int n, input int last_at);
        int k;
        for (int b = 0; b < n; b++) begin
            in_valid = 1'b1;
            in_data = s[(b % NB)*BW +: BW];
            in_last = (b == last_at);
            k = 0;
            while (in_ready !== 1'b1 && k < 50) begin
                @(negedge clk);
                k++;
            end
            tests++;
            if (k == 50) begin
                fails++;
                $display("FAIL send_ready beat %0d: in_ready=%b required 1", b, in_ready);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic run_frame(input logic [SW-1:0] s, input logic [SW-1:0] r, input int lat, input int mode);
        int k, beat, acc, pi, st0, ei;
        logic [2:0] esi;
        logic [3:0] pat = 4'b1001;
        eng_res = r;
        eng_lat = lat;
        st0 = eng_starts;
        send(s, NB, NB - 1);
        tests++;
        if (eng_start !== 1'b1 || eng_string !== s) begin
            fails++;
            $display("FAIL launch: eng_start=%b eng_string=%h required 1 %h", eng_start, eng_string, s);
        end
        @(negedge clk);
        k = 1;
        tests++;
        if (eng_start !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL wait_entry: start/busy/in_ready=%b%b%b required 010", eng_start, busy, in_ready);
        end
        while (out_valid !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (k != lat + 1) begin
            fails++;
            $display("FAIL latency: %0d cycles required %0d", k, lat + 1);
        end
        tests++;
        if (eng_starts != st0 + 1) begin
            fails++;
            $display("FAIL start_count: %0d pulses required 1", eng_starts - st0);
        end
        ei = ref_idx(r);
        esi = (ei < 0) ? 3'd0 : 3'(ei);
        tests++;
        if (sentinel_idx !== esi || err_nosentinel !== (ei < 0) || err_len !== 1'b0 || err_timeout !== 1'b0) begin
            fails++;
            $display("FAIL capture: idx=%0d nosent=%b len=%b to=%b required idx=%0d nosent=%b len=0 to=0",
                     sentinel_idx, err_nosentinel, err_len, err_timeout, esi, ei < 0);
        end
        beat = 0;
        acc = 0;
        pi = 0;
        while (out_valid === 1'b1 && k < 200) begin
            out_ready = mode == 0 ? 1'b1 : mode == 1 ? pat[pi % 4] : 1'($urandom_range(0, 1));
            pi++;
            tests++;
            if (out_data !== r[beat*BW +: BW] || out_last !== (beat == NB - 1) || sentinel_idx !== esi) begin
                fails++;
                $display("FAIL out_beat %0d: data=%h last=%b idx=%0d required %h %b %0d",
                         beat, out_data, out_last, sentinel_idx, r[beat*BW +: BW], beat == NB - 1, esi);
            end
            if (out_ready) begin
                beat++;
                acc++;
            end
            @(negedge clk);
            k++;
        end
        out_ready = 1'b0;
        tests++;
        if (acc != NB || in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL drain: accepted=%0d in_ready=%b busy=%b required %0d 1 0", acc, in_ready, busy, NB);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({in_ready, out_valid, out_last, eng_start, busy, err_len, err_timeout, err_nosentinel} !== 8'b1000_0000) begin
            fails++;
            $display("FAIL reset_ctrl: flags=%b required 10000000",
                     {in_ready, out_valid, out_last, eng_start, busy, err_len, err_timeout, err_nosentinel});
        end
        tests++;
        if (out_data !== '0 || eng_string !== '0 || sentinel_idx !== '0) begin
            fails++;
            $display("FAIL reset_data: out_data=%h eng_string=%h idx=%0d required zeros", out_data, eng_string, sentinel_idx);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: in_ready=%b busy=%b required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_basic();
        run_frame(pack("ACGTACG$"), pack("GT$CAACG"), 10, 0);
    endtask

    task automatic test_stall();
        run_frame(pack("ACGTACG$"), pack("GT$CAACG"), 10, 1);
    endtask

    task automatic test_short_frame();
        int st0 = eng_starts;
        send(pack("ACGTACG$"), 1, 0);
        tests++;
        if (err_len !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL short_frame: err_len=%b busy=%b in_ready=%b required 1 0 1", err_len, busy, in_ready);
        end
        repeat (12) @(negedge clk);
        tests++;
        if (eng_starts != st0 || err_len !== 1'b1) begin
            fails++;
            $display("FAIL short_nostart: starts=%0d err_len=%b required 0 1", eng_starts - st0, err_len);
        end
        run_frame(pack("TTGCA$GA"), pack("AG$TTGCA"), 7, 0);
    endtask

    task automatic test_long_frame();
        int st0 = eng_starts;
        logic [SW-1:0] s = rand_str(1'b1);
        send(s, 2, -1);
        tests++;
        if (err_len !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL long_discard: err_len=%b busy=%b in_ready=%b required 1 1 1", err_len, busy, in_ready);
        end
        send(s, 1, 0);
        tests++;
        if (err_len !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL long_return: err_len=%b busy=%b in_ready=%b required 1 0 1", err_len, busy, in_ready);
        end
        repeat (12) @(negedge clk);
        tests++;
        if (eng_starts != st0) begin
            fails++;
            $display("FAIL long_nostart: starts=%0d required 0", eng_starts - st0);
        end
        run_frame(rand_str(1'b1), rand_str(1'b1), 4, 0);
    endtask

    task automatic test_timeout();
        int st0 = eng_starts;
        bit seen = 1'b0;
        eng_res = pack("GT$CAACG");
        eng_lat = 20;
        send(rand_str(1'b1), NB, NB - 1);
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
            if (k == 16) begin
                tests++;
                if (busy !== 1'b1 || err_timeout !== 1'b0) begin
                    fails++;
                    $display("FAIL timeout_early: busy=%b err_timeout=%b required 1 0", busy, err_timeout);
                end
            end
            if (k == 17) begin
                tests++;
                if (busy !== 1'b0 || err_timeout !== 1'b1 || in_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL timeout_fire: busy=%b err_timeout=%b in_ready=%b required 0 1 1", busy, err_timeout, in_ready);
                end
            end
        end
        tests++;
        if (seen || err_timeout !== 1'b1 || busy !== 1'b0 || eng_starts != st0 + 1) begin
            fails++;
            $display("FAIL late_done: out_valid_seen=%b err_timeout=%b busy=%b starts=%0d required 0 1 0 1",
                     seen, err_timeout, busy, eng_starts - st0);
        end
    endtask

    task automatic test_boundary_latency();
        run_frame(rand_str(1'b1), pack("CA$GTACG"), TO, 0);
        run_frame(rand_str(1'b1), pack("ACGTACG$"), 1, 0);
    endtask

    task automatic test_nosentinel_reset();
        logic [SW-1:0] r = rand_str(1'b0);
        int k = 0;
        run_frame(rand_str(1'b1), r, 5, 0);
        eng_res = rand_str(1'b0);
        eng_lat = 3;
        send(rand_str(1'b1), NB, NB - 1);
        while (out_valid !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (out_valid !== 1'b1 || err_nosentinel !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_send: out_valid=%b err_nosentinel=%b required 1 1", out_valid, err_nosentinel);
        end
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || err_nosentinel !== 1'b0 ||
            sentinel_idx !== '0 || eng_string !== '0) begin
            fails++;
            $display("FAIL mid_reset: out_valid=%b in_ready=%b busy=%b nosent=%b idx=%0d required 0 1 0 0 0",
                     out_valid, in_ready, busy, err_nosentinel, sentinel_idx);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_frame(rand_str(1'b1), rand_str(1'b1), $urandom_range(1, TO), 2);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_short_frame();
        test_long_frame();
        test_timeout();
        test_boundary_latency();
        test_nosentinel_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
